// File: rtl/uart_bps_gen_if.sv
// UART bit-timing bundle between the control FSMs (master) and the bit-timing generator (slave).
// Carries the run request and baud select in one direction and the timing strobes and bit index in the other.
interface uart_bps_gen_if #(
  parameter int unsigned FRAME_BITS = 10
);
  localparam int unsigned IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  logic             Count_Sig;
  logic [1:0]       Baud_Sel;
  logic             Busy;
  logic             BPS_CLK;
  logic             Bit_End;
  logic [IDX_W-1:0] Bit_Idx;
  logic             Frame_Done;
  logic             Sample_Tick;

  modport master (
    output Count_Sig,
    output Baud_Sel,
    input  Busy,
    input  BPS_CLK,
    input  Bit_End,
    input  Bit_Idx,
    input  Frame_Done,
    input  Sample_Tick
  );

  modport slave (
    input  Count_Sig,
    input  Baud_Sel,
    output Busy,
    output BPS_CLK,
    output Bit_End,
    output Bit_Idx,
    output Frame_Done,
    output Sample_Tick
  );
endinterface

// File: rtl/uart_bps_gen.sv
// UART bit timer: four runtime baud rates, mid-bit/bit-end/frame-done strobes decoded from registers (0-cycle decode).
// No backpressure; Count_Sig low aborts the frame on the next edge. Oversample tick enabled by UART_BPS_OVERSAMPLE_EN.
module uart_bps_gen #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD0      = 9600,
  parameter int unsigned BAUD1      = 19200,
  parameter int unsigned BAUD2      = 57600,
  parameter int unsigned BAUD3      = 115200,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned CNT_W      = 13,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           CLK,
  input  logic           RSTn,
  uart_bps_gen_if.slave  bus
);

  localparam int unsigned IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  function automatic int unsigned raw_div(input int unsigned baud);
    int unsigned d;
    d = CLK_FREQ / baud;
    if (d < 2) d = 2;
    return d;
  endfunction

  localparam int unsigned RD0 = raw_div(BAUD0);
  localparam int unsigned RD1 = raw_div(BAUD1);
  localparam int unsigned RD2 = raw_div(BAUD2);
  localparam int unsigned RD3 = raw_div(BAUD3);
  localparam int unsigned RD_MAX01 = (RD0 > RD1) ? RD0 : RD1;
  localparam int unsigned RD_MAX23 = (RD2 > RD3) ? RD2 : RD3;
  localparam int unsigned RD_MAX   = (RD_MAX01 > RD_MAX23) ? RD_MAX01 : RD_MAX23;

  localparam logic [CNT_W-1:0] D0 = CNT_W'(RD0);
  localparam logic [CNT_W-1:0] D1 = CNT_W'(RD1);
  localparam logic [CNT_W-1:0] D2 = CNT_W'(RD2);
  localparam logic [CNT_W-1:0] D3 = CNT_W'(RD3);
  localparam logic [CNT_W-1:0] H0 = CNT_W'(RD0 / 2);
  localparam logic [CNT_W-1:0] H1 = CNT_W'(RD1 / 2);
  localparam logic [CNT_W-1:0] H2 = CNT_W'(RD2 / 2);
  localparam logic [CNT_W-1:0] H3 = CNT_W'(RD3 / 2);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  // A counter too narrow for the slowest divisor would silently wrap and corrupt every bit.
  if (OVERSAMPLE < 1 || RD_MAX > (32'd1 << CNT_W)) begin : g_cfg_err
    $error("uart_bps_gen: CNT_W too narrow for the largest divisor, or OVERSAMPLE < 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] sel_div, sel_half;
  logic             busy;
  logic             bit_end;
  logic             last_bit;

  always_comb begin
    sel_div  = D0;
    sel_half = H0;
    case (bus.Baud_Sel)
      2'd1: begin
        sel_div  = D1;
        sel_half = H1;
      end
      2'd2: begin
        sel_div  = D2;
        sel_half = H2;
      end
      2'd3: begin
        sel_div  = D3;
        sel_half = H3;
      end
      default: begin
        sel_div  = D0;
        sel_half = H0;
      end
    endcase
  end

  assign busy     = (state_q == RUN);
  assign bit_end  = busy && (cnt_q == div_q - 1'b1);
  assign last_bit = (bit_idx_q == LAST_IDX);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= D0;
      half_q    <= H0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      half_q    <= half_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    half_d    = half_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (bus.Count_Sig) begin
          state_d   = RUN;
          div_d     = sel_div;
          half_d    = sel_half;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      RUN: begin
        // Abort has priority over a coincident bit end: the partial frame is discarded.
        if (!bus.Count_Sig) begin
          state_d   = IDLE;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = last_bit ? '0 : bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  assign bus.Busy       = busy;
  assign bus.BPS_CLK    = busy && (cnt_q == half_q);
  assign bus.Bit_End    = bit_end;
  assign bus.Bit_Idx    = bit_idx_q;
  assign bus.Frame_Done = bit_end && last_bit;

`ifdef UART_BPS_OVERSAMPLE_EN
  function automatic logic [CNT_W-1:0] sub_of(input int unsigned d);
    int unsigned s;
    s = d / OVERSAMPLE;
    if (s < 1) s = 1;
    return CNT_W'(s);
  endfunction

  localparam logic [CNT_W-1:0] S0 = sub_of(RD0);
  localparam logic [CNT_W-1:0] S1 = sub_of(RD1);
  localparam logic [CNT_W-1:0] S2 = sub_of(RD2);
  localparam logic [CNT_W-1:0] S3 = sub_of(RD3);

  logic [CNT_W-1:0] sub_div_q, sub_div_d;
  logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [CNT_W-1:0] sel_sub;
  logic             sub_wrap;

  always_comb begin
    case (bus.Baud_Sel)
      2'd1:    sel_sub = S1;
      2'd2:    sel_sub = S2;
      2'd3:    sel_sub = S3;
      default: sel_sub = S0;
    endcase
  end

  assign sub_wrap = (sub_cnt_q == sub_div_q - 1'b1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sub_div_q <= S0;
      sub_cnt_q <= '0;
    end else begin
      sub_div_q <= sub_div_d;
      sub_cnt_q <= sub_cnt_d;
    end
  end

  // Restarting on every bit end keeps the tick grid aligned to the bit even when S does not divide D.
  always_comb begin
    sub_div_d = sub_div_q;
    sub_cnt_d = sub_cnt_q;
    if (state_q == IDLE) begin
      sub_cnt_d = '0;
      if (bus.Count_Sig) sub_div_d = sel_sub;
    end else if (!bus.Count_Sig || bit_end || sub_wrap) begin
      sub_cnt_d = '0;
    end else begin
      sub_cnt_d = sub_cnt_q + 1'b1;
    end
  end

  assign bus.Sample_Tick = busy && sub_wrap;
`else
  assign bus.Sample_Tick = 1'b0;
`endif

endmodule

// File: doc/uart_bps_gen.md
Name: uart_bps_gen

Overview:
- Parametrised UART bit-timing generator for the RX and TX paths. It replaces the fixed 9600-baud divider with four runtime-selectable baud rates.
- Emits a mid-bit sample strobe and a bit-end strobe, tracks the bit index within a frame, and pulses frame-done.
- Sits between the UART control FSMs (which drive Count_Sig) and the shift registers.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD0, 9600, baud rate for Baud_Sel=0
- BAUD1, 19200, baud rate for Baud_Sel=1
- BAUD2, 57600, baud rate for Baud_Sel=2
- BAUD3, 115200, baud rate for Baud_Sel=3
- FRAME_BITS, 10, bits per frame (start+data+stop)
- CNT_W, 13, bit-counter width; must hold max divisor minus 1
- OVERSAMPLE, 16, oversample ratio (optional feature only)

Ports:
- CLK  in  1  system clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- Count_Sig  in  1  run request; high = timing active
- Baud_Sel  in  2  baud select, latched at frame start
- Busy  out  1  timing active
- BPS_CLK  out  1  one-cycle mid-bit strobe
- Bit_End  out  1  one-cycle strobe on last cycle of each bit
- Bit_Idx  out  $clog2(FRAME_BITS)  current bit number, 0-based
- Frame_Done  out  1  one-cycle pulse on Bit_End of bit FRAME_BITS-1
- Sample_Tick  out  1  oversample strobe (see Optional Feature)

Behaviour:
- Reset (RSTn=0, async): Busy=0, count=0, Bit_Idx=0, latched divisor=D(BAUD0). All strobes=0.
- Divisor Dn = CLK_FREQ/BAUDn, integer truncation, computed at elaboration. Any Dn<2 is clamped to 2. Half point H = D/2, truncated.
- IDLE (Busy=0): first edge with Count_Sig=1 latches D from Baud_Sel, sets Busy=1, count=0, Bit_Idx=0. Call this edge t0.
- RUN (Busy=1), each edge with Count_Sig=1: count = (count==D-1) ? 0 : count+1. Count after edge t0+k is k mod D.
- Baud_Sel changes while Busy=1 are ignored until the next IDLE->RUN.
- BPS_CLK = Busy & (count==H). Decoded from registers only, so it is glitch-free.
- Bit_End = Busy & (count==D-1).
- Bit_Idx increments on the edge where Bit_End=1. It wraps to 0 after FRAME_BITS-1.
- Frame_Done = Bit_End & (Bit_Idx==FRAME_BITS-1).
- Continuous Count_Sig produces back-to-back frames with no gap cycle.
- Count_Sig=0 in RUN: next edge forces Busy=0, count=0, Bit_Idx=0. No Frame_Done is issued for the partial frame. Count_Sig high again is a fresh t0 with a new Baud_Sel latch.
- Count_Sig=0 on the same edge as Bit_End: the abort wins, and Bit_Idx goes to 0, not +1.
- Reset mid-frame returns to reset values immediately. No strobe survives it.
- Strobes are never asserted while Busy=0.

Optional Feature:
- Macro: UART_BPS_OVERSAMPLE_EN.
- Defined:
  - Sub-divisor S = D/OVERSAMPLE, truncated, minimum 1.
  - Sub-counter runs 0..S-1 in RUN. Sample_Tick=1 when subcount==S-1.
  - Sub-counter is cleared on Bit_End and on leaving RUN. This gives exactly OVERSAMPLE ticks per bit when D>=OVERSAMPLE, with the last tick at count OVERSAMPLE*S-1.
- Undefined: Sample_Tick tied to 0, no sub-counter logic.

Test Plan:
- Reset hold then release, Count_Sig=0 -> Busy=0, Bit_Idx=0, BPS_CLK/Bit_End/Frame_Done/Sample_Tick all 0 for 10000 cycles.
- Baud_Sel=0, Count_Sig held high -> BPS_CLK after edges t0+2604, t0+7812. Bit_End after t0+5207. Frame_Done once after t0+52079, then Bit_Idx=0 and next BPS_CLK after t0+54684.
- Baud_Sel=3 (D=434, H=217) -> BPS_CLK period 434 cycles. Baud_Sel driven to 0 mid-frame leaves the period unchanged until Count_Sig drops and restarts.
- Baud_Sel=1 (D=2604), Count_Sig dropped after edge t0+3000 -> Busy=0 next edge, Bit_Idx=0, no Frame_Done. Re-asserting with Baud_Sel=2 gives BPS_CLK 434 cycles after the new t0.
- RSTn pulsed low at t0+1302 with Baud_Sel=2 -> all outputs 0 immediately. After release, latched divisor is D0=5208.
- UART_BPS_OVERSAMPLE_EN defined, Baud_Sel=3 (S=27) -> 16 Sample_Tick pulses per bit at counts 26,53,...,431. None at 432-433. Without the macro, Sample_Tick stays 0.
